// File: rtl/sram_2r1w_arbiter_if.sv
// Client/SRAM-facing bus of sram_2r1w_arbiter: per-requester read/write handshakes
// plus the two read ports and one write port of the shared sram_2r1w macro.
interface sram_2r1w_arbiter_if #(
  parameter int NUM_READERS = 4,
  parameter int NUM_WRITERS = 2,
  parameter int DATA_WIDTH  = 32,
  parameter int SIZE        = 64,
  parameter int ADDR_WIDTH  = $clog2(SIZE)
);
  logic [NUM_READERS-1:0]                 rd_req;
  logic [NUM_READERS-1:0][ADDR_WIDTH-1:0] rd_adr;
  logic [NUM_READERS-1:0]                 rd_grant;
  logic [NUM_READERS-1:0]                 rd_resp_valid;
  logic [NUM_READERS-1:0][DATA_WIDTH-1:0] rd_resp_data;

  logic [NUM_WRITERS-1:0]                 wr_req;
  logic [NUM_WRITERS-1:0][ADDR_WIDTH-1:0] wr_adr;
  logic [NUM_WRITERS-1:0][DATA_WIDTH-1:0] wr_data;
  logic [NUM_WRITERS-1:0]                 wr_grant;

  logic                                   read1_en;
  logic                                   read2_en;
  logic [ADDR_WIDTH-1:0]                  read1_adr;
  logic [ADDR_WIDTH-1:0]                  read2_adr;
  logic [DATA_WIDTH-1:0]                  read1_data;
  logic [DATA_WIDTH-1:0]                  read2_data;
  logic                                   write_en;
  logic [ADDR_WIDTH-1:0]                  write_adr;
  logic [DATA_WIDTH-1:0]                  write_data;

  // Requesters and the SRAM macro together form the environment side.
  modport master (
    output rd_req, rd_adr, wr_req, wr_adr, wr_data, read1_data, read2_data,
    input  rd_grant, rd_resp_valid, rd_resp_data, wr_grant,
           read1_en, read2_en, read1_adr, read2_adr, write_en, write_adr, write_data
  );

  modport slave (
    input  rd_req, rd_adr, wr_req, wr_adr, wr_data, read1_data, read2_data,
    output rd_grant, rd_resp_valid, rd_resp_data, wr_grant,
           read1_en, read2_en, read1_adr, read2_adr, write_en, write_adr, write_data
  );
endinterface

// File: rtl/sram_2r1w_arbiter.sv
// Round-robin arbiter sharing one sram_2r1w among several readers and writers,
// with read response routing and write-to-read forwarding on address collisions.
module sram_2r1w_arbiter #(
  parameter int NUM_READERS = 4,
  parameter int NUM_WRITERS = 2,
  parameter int DATA_WIDTH  = 32,
  parameter int SIZE        = 64,
  parameter int ADDR_WIDTH  = $clog2(SIZE)
) (
  input logic                clk,
  input logic                reset,
  sram_2r1w_arbiter_if.slave bus
);

  localparam int RIDX_W = (NUM_READERS > 1) ? $clog2(NUM_READERS) : 1;
  localparam int WIDX_W = (NUM_WRITERS > 1) ? $clog2(NUM_WRITERS) : 1;
  localparam logic [RIDX_W-1:0] RD_LAST = RIDX_W'(NUM_READERS - 1);
  localparam logic [WIDX_W-1:0] WR_LAST = WIDX_W'(NUM_WRITERS - 1);

  logic [RIDX_W-1:0]      rd_ptr;
  logic [RIDX_W-1:0]      rd_ptr_nxt;
  logic [RIDX_W-1:0]      sel1_idx;
  logic [RIDX_W-1:0]      sel2_idx;
  logic                   sel1_v;
  logic                   sel2_v;
  logic [NUM_READERS-1:0] rd_gnt;

  logic [WIDX_W-1:0]      wr_ptr;
  logic [WIDX_W-1:0]      wr_ptr_nxt;
  logic [WIDX_W-1:0]      wsel_idx;
  logic                   wsel_v;
  logic [NUM_WRITERS-1:0] wr_gnt;

  logic [ADDR_WIDTH-1:0]  rd1_adr;
  logic [ADDR_WIDTH-1:0]  rd2_adr;
  logic [ADDR_WIDTH-1:0]  wr_adr_sel;
  logic [DATA_WIDTH-1:0]  wr_data_sel;
  logic                   hit1;
  logic                   hit2;

  logic [NUM_READERS-1:0]                 resp_valid_q;
  logic                                   p1_v;
  logic                                   p2_v;
  logic [RIDX_W-1:0]                      p1_idx;
  logic [RIDX_W-1:0]                      p2_idx;
  logic                                   byp1;
  logic                                   byp2;
  logic [DATA_WIDTH-1:0]                  byp_data;
  logic [NUM_READERS-1:0][DATA_WIDTH-1:0] resp_hold;
  logic [NUM_READERS-1:0][DATA_WIDTH-1:0] resp_data_c;

  // Scan from rd_ptr with wrap; first two requesters take ports 1 and 2.
  always_comb begin : rd_arb
    int unsigned       j;
    logic [RIDX_W-1:0] jj;
    rd_gnt   = '0;
    sel1_v   = 1'b0;
    sel2_v   = 1'b0;
    sel1_idx = '0;
    sel2_idx = '0;
    j        = 0;
    jj       = '0;
    for (int unsigned k = 0; k < NUM_READERS; k++) begin
      j = 32'(rd_ptr) + k;
      if (j >= NUM_READERS) j = j - NUM_READERS;
      jj = RIDX_W'(j);
      if (bus.rd_req[jj] && !reset) begin
        if (!sel1_v) begin
          sel1_v     = 1'b1;
          sel1_idx   = jj;
          rd_gnt[jj] = 1'b1;
        end else if (!sel2_v) begin
          sel2_v     = 1'b1;
          sel2_idx   = jj;
          rd_gnt[jj] = 1'b1;
        end
      end
    end
  end

  always_comb begin : rd_ptr_calc
    rd_ptr_nxt = rd_ptr;
    if (sel2_v) begin
      rd_ptr_nxt = (sel2_idx == RD_LAST) ? '0 : sel2_idx + 1'b1;
    end else if (sel1_v) begin
      rd_ptr_nxt = (sel1_idx == RD_LAST) ? '0 : sel1_idx + 1'b1;
    end
  end

  always_comb begin : wr_arb
    int unsigned       j;
    logic [WIDX_W-1:0] jj;
    wr_gnt   = '0;
    wsel_v   = 1'b0;
    wsel_idx = '0;
    j        = 0;
    jj       = '0;
    for (int unsigned k = 0; k < NUM_WRITERS; k++) begin
      j = 32'(wr_ptr) + k;
      if (j >= NUM_WRITERS) j = j - NUM_WRITERS;
      jj = WIDX_W'(j);
      if (bus.wr_req[jj] && !reset && !wsel_v) begin
        wsel_v     = 1'b1;
        wsel_idx   = jj;
        wr_gnt[jj] = 1'b1;
      end
    end
  end

  always_comb begin : wr_ptr_calc
    wr_ptr_nxt = wr_ptr;
    if (wsel_v) begin
      wr_ptr_nxt = (wsel_idx == WR_LAST) ? '0 : wsel_idx + 1'b1;
    end
  end

  assign rd1_adr     = bus.rd_adr[sel1_idx];
  assign rd2_adr     = bus.rd_adr[sel2_idx];
  assign wr_adr_sel  = bus.wr_adr[wsel_idx];
  assign wr_data_sel = bus.wr_data[wsel_idx];

  // The SRAM may return anything on a same-cycle collision, so remember the write.
  assign hit1 = sel1_v && wsel_v && (rd1_adr == wr_adr_sel);
  assign hit2 = sel2_v && wsel_v && (rd2_adr == wr_adr_sel);

  assign bus.rd_grant   = rd_gnt;
  assign bus.wr_grant   = wr_gnt;
  assign bus.read1_en   = sel1_v;
  assign bus.read2_en   = sel2_v;
  assign bus.read1_adr  = rd1_adr;
  assign bus.read2_adr  = rd2_adr;
  assign bus.write_en   = wsel_v;
  assign bus.write_adr  = wr_adr_sel;
  assign bus.write_data = wr_data_sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      resp_valid_q <= '0;
      p1_v         <= 1'b0;
      p2_v         <= 1'b0;
      p1_idx       <= '0;
      p2_idx       <= '0;
      byp1         <= 1'b0;
      byp2         <= 1'b0;
      byp_data     <= '0;
      resp_hold    <= '0;
    end else begin
      rd_ptr       <= rd_ptr_nxt;
      wr_ptr       <= wr_ptr_nxt;
      resp_valid_q <= rd_gnt;
      p1_v         <= sel1_v;
      p2_v         <= sel2_v;
      p1_idx       <= sel1_idx;
      p2_idx       <= sel2_idx;
      byp1         <= hit1;
      byp2         <= hit2;
      if (hit1 || hit2) byp_data <= wr_data_sel;
      resp_hold    <= resp_data_c;
    end
  end

  // SRAM data arrives the cycle after the grant; route it to the reader that asked.
  always_comb begin
    resp_data_c = resp_hold;
    for (int unsigned i = 0; i < NUM_READERS; i++) begin
      if (p1_v && (p1_idx == RIDX_W'(i))) begin
        resp_data_c[i] = byp1 ? byp_data : bus.read1_data;
      end else if (p2_v && (p2_idx == RIDX_W'(i))) begin
        resp_data_c[i] = byp2 ? byp_data : bus.read2_data;
      end
    end
  end

  assign bus.rd_resp_valid = resp_valid_q;
  assign bus.rd_resp_data  = resp_data_c;

endmodule
